// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a small FIFO,
// STATUS reports FIFO/FSM state and a sticky overflow flag.
module uart_tx_mmio #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        cpu_resetn,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  state_t        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q;
  logic          tx_d;
  logic          pop;

  // Bus handshake: sel is a one-cycle strobe with no ready/backpressure;
  // every access completes in the cycle it is presented, a full FIFO drops.
  logic fifo_empty, fifo_full, wr_txdata, wr_status, push_ok, push_drop;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign wr_txdata  = sel && we && (addr == 4'h0);
  assign wr_status  = sel && we && (addr == 4'h4);
  assign push_ok    = wr_txdata && (!fifo_full || pop);
  assign push_drop  = wr_txdata && fifo_full && !pop;

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx      <= tx_d;
      if (pop) shift_q <= mem[rd_ptr];
    end
  end

  // Baud counter counts CLK_DIV-1 down to 0; each phase advances on 0.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
          baud_d  = BAUD_MAX;
        end
      end
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          baud_d  = BAUD_MAX;
          bit_d   = '0;
        end else baud_d = baud_q - 16'd1;
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_MAX;
          if (bit_q == 3'd7) state_d = STOP;
          else bit_d = bit_q + 3'd1;
        end else baud_d = baud_q - 16'd1;
      end
      STOP: begin
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
            baud_d  = BAUD_MAX;
          end else begin
            state_d = IDLE;
            baud_d  = '0;
          end
        end else baud_d = baud_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is registered, so tx lags the FSM state by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[bit_q];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (push_drop) ovf <= 1'b1;
      else if (wr_status && wdata[3]) ovf <= 1'b0;
    end
  end

  logic [4:0] count5;
  logic       busy;
  assign count5 = 5'(count);
  assign busy   = (state_q != IDLE);

  always_comb begin
    rdata = '0;
    if (sel && !we && (addr == 4'h4))
      rdata = {23'b0, count5, ovf, busy, fifo_empty, fifo_full};
  end

  assign dbg_state = state_q;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomized self-checking bench for uart_tx_mmio: a timing-level model
// predicts each frame's start cycle and bits, a line monitor checks them.
module tb_uart_tx_mmio;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        cpu_resetn;
  logic        sel, we;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic        tx;
  logic [1:0]  dbg_state;

  uart_tx_mmio #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .cpu_resetn(cpu_resetn), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .tx(tx), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Byte accepted at write edge t starts at max(t+2, previous start + 10*DIV);
  // it sits in the FIFO until the edge one before its start.
  logic [7:0] exp_q[$];
  int         exp_t[$];
  int         sched_w[$];
  int         sched_s[$];
  int         last_s;
  logic       ovf_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_t.delete();
    sched_w.delete();
    sched_s.delete();
    last_s = -1000;
    ovf_m  = 1'b0;
  endtask

  function automatic int count_at(input int t);
    int n = 0;
    for (int i = 0; i < sched_w.size(); i++)
      if (sched_w[i] <= t && sched_s[i] - 1 > t) n++;
    return n;
  endfunction

  function automatic bit busy_at(input int t);
    for (int i = 0; i < sched_s.size(); i++)
      if (t >= sched_s[i] - 1 && t <= sched_s[i] + 10 * DIV - 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] status_at(input int t);
    int         c;
    logic [4:0] c5;
    c  = count_at(t);
    c5 = 5'(c);
    return {23'b0, c5, ovf_m, busy_at(t), (c == 0), (c == DEPTH)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    int t, occ, s;
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    t = cyc + 1;
    if (a == 4'h0) begin
      occ = 0;
      for (int i = 0; i < sched_w.size(); i++)
        if (sched_w[i] < t && sched_s[i] - 1 > t) occ++;
      if (occ < DEPTH) begin
        s = (t + 2 > last_s + 10 * DIV) ? t + 2 : last_s + 10 * DIV;
        sched_w.push_back(t);
        sched_s.push_back(s);
        last_s = s;
        exp_q.push_back(d[7:0]);
        exp_t.push_back(s);
      end else ovf_m = 1'b1;
    end else if (a == 4'h4 && d[3]) ovf_m = 1'b0;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input string name);
    logic [31:0] e;
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    e = (a == 4'h4) ? status_at(cyc) : 32'h0;
    check(name, rdata, e);
    sel = 1'b0;
  endtask

  // ---------------- line monitor / scoreboard ----------------
  logic       in_frame = 1'b0;
  logic [9:0] mon_bits, got_bits;
  int         mon_idx, bad_cycles;

  always @(negedge clk) begin
    if (!cpu_resetn) in_frame = 1'b0;
    else begin
      if (!in_frame && tx === 1'b0) begin
        if (exp_q.size() == 0) check("unexpected_start", {31'b0, tx}, 32'd1);
        else begin
          mon_bits = {1'b1, exp_q.pop_front(), 1'b0};
          check("frame_start_cycle", cyc, exp_t.pop_front());
          got_bits   = '0;
          bad_cycles = 0;
          mon_idx    = 0;
          in_frame   = 1'b1;
        end
      end
      if (in_frame) begin
        if (tx !== mon_bits[mon_idx / DIV]) bad_cycles++;
        if (mon_idx % DIV == DIV / 2) got_bits[mon_idx / DIV] = tx;
        mon_idx++;
        if (mon_idx == 10 * DIV) begin
          check("frame_bits", {22'b0, got_bits}, {22'b0, mon_bits});
          check("frame_bit_width", bad_cycles, 0);
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_within_budget", {31'b0, (n < budget)}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int low_cycles;
    int choice;
    cpu_resetn = 1'b0;
    sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    cpu_resetn = 1'b1;

    // reset state
    check("reset_tx", {31'b0, tx}, 32'd1);
    bus_read(4'h4, "reset_status");

    // single frame, upper data bits ignored
    bus_write(4'h0, 32'hFFFF_FFA5);
    repeat (10) @(negedge clk);
    bus_read(4'h4, "status_busy");
    wait_drain(200);
    bus_read(4'h4, "status_after_frame");

    // burst until full, then overflow
    for (int i = 1; i <= 6; i++) bus_write(4'h0, 32'(i));
    bus_read(4'h4, "status_full_ovf");
    bus_write(4'h4, 32'hFFFF_FFF7);
    bus_read(4'h4, "status_no_clear");
    bus_write(4'h4, 32'h0000_0008);
    bus_read(4'h4, "status_ovf_cleared");
    wait_drain(600);

    // reserved offsets
    bus_write(4'hC, 32'h0000_003C);
    bus_write(4'h8, 32'h0000_0055);
    bus_read(4'hC, "reserved_read");
    bus_read(4'h4, "status_after_reserved");

    // reset in bit 3 of a frame with two bytes queued
    bus_write(4'h0, 32'h00);
    bus_write(4'h0, 32'h11);
    bus_write(4'h0, 32'h22);
    repeat (18) @(negedge clk);
    #2 cpu_resetn = 1'b0;
    #1 check("reset_tx_async", {31'b0, tx}, 32'd1);
    sel = 1'b1; we = 1'b0; addr = 4'h4;
    #1 check("status_in_reset", rdata, 32'h2);
    sel = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    cpu_resetn = 1'b1;
    bus_read(4'h4, "status_after_reset");
    low_cycles = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cycles++;
    end
    check("tx_idle_after_reset", low_cycles, 0);

    // randomized traffic
    for (int k = 0; k < 80; k++) begin
      choice = $urandom_range(0, 9);
      if (choice <= 5)      bus_write(4'h0, $urandom);
      else if (choice == 6) bus_write(4'h4, $urandom);
      else if (choice == 7) bus_write(($urandom_range(0, 1) != 0) ? 4'h8 : 4'hC, $urandom);
      else if (choice == 8) bus_read(4'h4, "rand_status");
      else                  bus_read(4'hC, "rand_reserved");
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_drain(2000);
    bus_read(4'h4, "final_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
